imuldiv_int_div_iterative: RTL and testbench
============================================

IMULDIV_INT_DIV_ITERATIVE -- requirements
Module: imuldiv_int_div_iterative

Interface
REQ-001 SHALL have no parameters; operand width is fixed at 32 bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port divreq_msg_fn  input  1  operation select: 0 = signed, 1 = unsigned.
REQ-005 SHALL have port divreq_msg_a  input  32  dividend.
REQ-006 SHALL have port divreq_msg_b  input  32  divisor.
REQ-007 SHALL have port divreq_val  input  1  request valid.
REQ-008 SHALL have port divreq_rdy  output  1  request ready.
REQ-009 SHALL have port divresp_msg_result  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 SHALL have port divresp_val  output  1  response valid.
REQ-011 SHALL have port divresp_rdy  input  1  response ready.

Function
REQ-012 SHALL use control FSM states IDLE, CALC, SIGN, DONE.
REQ-013 SHALL assert divreq_rdy only in IDLE and divresp_val only in DONE; a transfer occurs only when val && rdy in the same cycle.
REQ-014 SHALL, on request handshake in cycle T, latch fn, operand signs and operand magnitudes; magnitudes are two's-complement negated only when fn=0 and the sign bit is 1.
REQ-015 SHALL run restoring division in CALC: 32 cycles, one quotient bit per cycle, using a 64-bit shifted remainder/dividend register and a 5-bit down-counter loaded with 31.
REQ-016 SHALL per CALC cycle: shift remainder left 1, subtract divisor from the upper half, keep the difference and set quotient bit 1 if non-negative, else restore and set quotient bit 0.
REQ-017 SHALL leave CALC for SIGN when the counter equals 0, and SIGN for DONE unconditionally; divresp_val is first asserted in cycle T+34.
REQ-018 SHALL in SIGN, when fn=0, negate the quotient if sign_a ^ sign_b, and negate the remainder if sign_a; when fn=1 no correction is applied.
REQ-019 SHALL, for divisor zero (either fn), produce quotient 0xFFFFFFFF and remainder equal to the original dividend.
REQ-020 SHALL, for signed 0x80000000 / 0xFFFFFFFF, produce quotient 0x80000000 and remainder 0.
REQ-021 SHALL hold divresp_msg_result stable while in DONE with divresp_rdy low.
REQ-022 SHALL return from DONE to IDLE on response handshake; a new request is accepted no earlier than the following cycle; throughput is one operation per 35 cycles minimum.
REQ-023 SHALL ignore divreq_* inputs outside IDLE.

Reset
REQ-024 SHALL, with reset high at a rising edge, enter IDLE, clear result, remainder, quotient, divisor, sign and counter registers, and discard any in-flight operation.
REQ-025 SHALL drive divresp_val=0, divresp_msg_result=0 and divreq_rdy=1 in the cycle after reset deasserts.
REQ-026 SHALL treat reset asserted mid-CALC or in DONE identically to REQ-024; no response is produced for the aborted operation.

Configuration
REQ-027 SHALL recognise macro IMULDIV_DIV_ZERO_BYPASS_EN.
REQ-028 SHALL, with IMULDIV_DIV_ZERO_BYPASS_EN defined, go IDLE->DONE directly on a handshake with divisor zero, loading the REQ-019 result so that divresp_val asserts at T+1.
REQ-029 SHALL, without the macro, process divisor zero through the full CALC/SIGN sequence (latency T+34), with SIGN forcing the REQ-019 result.

Structure
REQ-030 SHALL place FSM state encodings (2 bits), fn encodings (DIV_FN_SIGNED=0, DIV_FN_UNSIGNED=1) and the counter reset value 31 in the shared imuldiv package.
REQ-031 SHALL split into control FSM in the top module plus one datapath sub-module imuldiv_int_div_iterative_dpath, connected by enable/mux-select and counter_is_zero/divisor_is_zero status signals.

Verification
REQ-032 SHALL cover fn=0, a=0x00000014, b=0xFFFFFFFD -> result {0x00000002, 0xFFFFFFFA}, divresp_val first high at T+34.
REQ-033 SHALL cover fn=1, a=0xFFFFFFFF, b=0x00000010 -> result {0x0000000F, 0x0FFFFFFF}.
REQ-034 SHALL cover fn=0, a=0xFFFFFFF9, b=0 -> result {0xFFFFFFF9, 0xFFFFFFFF}, at T+1 with the macro and T+34 without.
REQ-035 SHALL cover fn=0, a=0x80000000, b=0xFFFFFFFF -> result {0x00000000, 0x80000000}.
REQ-036 SHALL cover divresp_rdy held low 10 cycles in DONE -> result and divresp_val stable, divreq_rdy low; after handshake, a back-to-back request is accepted the next cycle.
REQ-037 SHALL cover reset asserted in the 10th CALC cycle -> next cycle IDLE, divreq_rdy=1, divresp_val=0, result 0, and no response for the aborted operation.

Source files
------------

// File: rtl/imuldiv_int_div_iterative_pkg.sv
// Shared types and constants for the iterative 32-bit integer divider.
// Consumed by the control FSM (top) and its datapath sub-module.
package imuldiv_int_div_iterative_pkg;

    localparam int unsigned DIV_WIDTH        = 32;
    localparam logic [4:0]  DIV_COUNTER_INIT = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_t;

    typedef enum logic {
        DIV_FN_SIGNED   = 1'b0,
        DIV_FN_UNSIGNED = 1'b1
    } div_fn_t;

    // Source of the value loaded into the result register.
    typedef enum logic [1:0] {
        RES_SEL_HOLD    = 2'd0,
        RES_SEL_SIGN    = 2'd1,
        RES_SEL_DIVZERO = 2'd2,
        RES_SEL_BYPASS  = 2'd3
    } div_res_sel_t;

    function automatic logic [DIV_WIDTH-1:0] negate_if(input logic [DIV_WIDTH-1:0] value,
                                                       input logic                 neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/imuldiv_int_div_iterative_dpath.sv
// Datapath of the iterative divider: operand magnitudes, restoring-division
// shift register, iteration counter and the sign-corrected result register.
module imuldiv_int_div_iterative_dpath
    import imuldiv_int_div_iterative_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         divreq_msg_fn,
    input  logic [31:0]  divreq_msg_a,
    input  logic [31:0]  divreq_msg_b,
    input  logic         load_en,
    input  logic         calc_en,
    input  div_res_sel_t result_sel,
    output logic         counter_is_zero,
    output logic         divisor_is_zero,
    output logic [63:0]  divresp_msg_result
);

    div_fn_t     fn_reg;
    logic        sign_a;
    logic        sign_b;
    logic [63:0] rem_quot;
    logic [31:0] divisor;
    logic [4:0]  counter;
    logic [63:0] result;

    logic        req_signed;
    logic        req_sign_a;
    logic        req_sign_b;
    logic        op_signed;
    logic [32:0] trial_diff;
    logic [63:0] rem_quot_step;
    logic [31:0] quot_fixed;
    logic [31:0] rem_fixed;

    assign req_signed = (div_fn_t'(divreq_msg_fn) == DIV_FN_SIGNED);
    assign req_sign_a = req_signed & divreq_msg_a[31];
    assign req_sign_b = req_signed & divreq_msg_b[31];
    assign op_signed  = (fn_reg == DIV_FN_SIGNED);

    // The trial subtraction includes the bit shifted out of the register so a
    // partial remainder with bit 31 set still compares correctly.
    assign trial_diff    = rem_quot[63:31] - {1'b0, divisor};
    assign rem_quot_step = trial_diff[32] ? {rem_quot[62:0], 1'b0}
                                          : {trial_diff[31:0], rem_quot[30:0], 1'b1};

    assign quot_fixed = negate_if(rem_quot[31:0], op_signed & (sign_a ^ sign_b));
    assign rem_fixed  = negate_if(rem_quot[63:32], op_signed & sign_a);

    // During the request cycle the status reflects the incoming divisor.
    assign divisor_is_zero    = load_en ? (divreq_msg_b == '0) : (divisor == '0);
    assign counter_is_zero    = (counter == '0);
    assign divresp_msg_result = result;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, regardless of block order.
    // NOTE: every register is cleared on reset, including the 64-bit
    // remainder/quotient register, so an aborted operation leaves no residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            fn_reg   <= DIV_FN_SIGNED;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            rem_quot <= '0;
            divisor  <= '0;
            counter  <= '0;
        end else if (load_en) begin
            fn_reg   <= div_fn_t'(divreq_msg_fn);
            sign_a   <= req_sign_a;
            sign_b   <= req_sign_b;
            rem_quot <= {32'd0, negate_if(divreq_msg_a, req_sign_a)};
            divisor  <= negate_if(divreq_msg_b, req_sign_b);
            counter  <= DIV_COUNTER_INIT;
        end else if (calc_en) begin
            rem_quot <= rem_quot_step;
            counter  <= counter - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
        end else begin
            case (result_sel)
                RES_SEL_SIGN:    result <= {rem_fixed, quot_fixed};
                RES_SEL_DIVZERO: result <= {rem_fixed, 32'hFFFF_FFFF};
                RES_SEL_BYPASS:  result <= {divreq_msg_a, 32'hFFFF_FFFF};
                default:         result <= result;
            endcase
        end
    end

endmodule

// File: rtl/imuldiv_int_div_iterative.sv
// Iterative 32-bit signed/unsigned divider with val/rdy request and response
// ports. Define IMULDIV_DIV_ZERO_BYPASS_EN to answer divide-by-zero in one cycle.
module imuldiv_int_div_iterative
    import imuldiv_int_div_iterative_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        divreq_msg_fn,
    input  logic [31:0] divreq_msg_a,
    input  logic [31:0] divreq_msg_b,
    input  logic        divreq_val,
    output logic        divreq_rdy,
    output logic [63:0] divresp_msg_result,
    output logic        divresp_val,
    input  logic        divresp_rdy
);

    div_state_t   state;
    div_state_t   state_next;
    logic         req_go;
    logic         resp_go;
    logic         load_en;
    logic         calc_en;
    div_res_sel_t result_sel;
    logic         counter_is_zero;
    logic         divisor_is_zero;

    assign req_go  = divreq_val & divreq_rdy;
    assign resp_go = divresp_val & divresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_go) begin
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
                    state_next = divisor_is_zero ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: if (counter_is_zero) state_next = SIGN;
            SIGN: state_next = DONE;
            DONE: if (resp_go) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        divreq_rdy  = (state == IDLE);
        divresp_val = (state == DONE);
        load_en     = (state == IDLE) & divreq_val;
        calc_en     = (state == CALC);
        result_sel  = RES_SEL_HOLD;
        if (state == SIGN) begin
            result_sel = divisor_is_zero ? RES_SEL_DIVZERO : RES_SEL_SIGN;
        end
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
        if (load_en && divisor_is_zero) begin
            result_sel = RES_SEL_BYPASS;
        end
`endif
    end

    imuldiv_int_div_iterative_dpath u_dpath (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .load_en            (load_en),
        .calc_en            (calc_en),
        .result_sel         (result_sel),
        .counter_is_zero    (counter_is_zero),
        .divisor_is_zero    (divisor_is_zero),
        .divresp_msg_result (divresp_msg_result)
    );

endmodule

// File: tb/tb_imuldiv_int_div_iterative.sv
// Scoreboard bench for imuldiv_int_div_iterative: a driver pushes reference
// results, a monitor pops and compares them whenever a response is presented.
module tb_imuldiv_int_div_iterative;

    logic        clk = 1'b0;
    logic        reset;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    logic        divreq_val;
    logic        divreq_rdy;
    logic [63:0] divresp_msg_result;
    logic        divresp_val;
    logic        divresp_rdy;

    typedef struct {
        logic [63:0] res;
        int          t_req;
        int          lat;
        int          stall;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   in_resp  = 0;
    bit   check_idle_next = 0;
    int   stall_left = 0;

    imuldiv_int_div_iterative dut (
        .clk                (clk),
        .reset              (reset),
        .divreq_msg_fn      (divreq_msg_fn),
        .divreq_msg_a       (divreq_msg_a),
        .divreq_msg_b       (divreq_msg_b),
        .divreq_val         (divreq_val),
        .divreq_rdy         (divreq_rdy),
        .divresp_msg_result (divresp_msg_result),
        .divresp_val        (divresp_val),
        .divresp_rdy        (divresp_rdy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic bound_expired(input string name);
        checks++;
        failures++;
        $display("FAIL %s wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: truncating division; x/0 gives all ones with remainder x,
    // and the one signed overflow case wraps to the dividend.
    function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (fn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    function automatic int ref_latency(input logic [31:0] b);
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
        if (b == 32'd0) return 1;
`endif
        return 34;
    endfunction

    // Holds a request until accepted; returns at the sample after the handshake edge.
    task automatic issue(input logic fn, input logic [31:0] a, input logic [31:0] b,
                         input bit record, input int stall, output bit ok);
        int waited = 0;
        exp_t e;
        ok            = 1'b0;
        divreq_msg_fn = fn;
        divreq_msg_a  = a;
        divreq_msg_b  = b;
        divreq_val    = 1'b1;
        while (!divreq_rdy) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 300) begin
                bound_expired("req_accept");
                divreq_val = 1'b0;
                return;
            end
        end
        if (record) begin
            e.res   = ref_div(fn, a, b);
            e.t_req = cyc;
            e.lat   = ref_latency(b);
            e.stall = stall;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        divreq_val    = 1'b0;
        divreq_msg_fn = 1'($urandom);
        divreq_msg_a  = $urandom;
        divreq_msg_b  = $urandom;
        ok            = 1'b1;
    endtask

    task automatic do_op(input logic fn, input logic [31:0] a, input logic [31:0] b, input int stall);
        bit ok;
        issue(fn, a, b, 1'b1, stall, ok);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_resp) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) bound_expired("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: owns divresp_rdy, compares each presented response to the scoreboard.
    initial begin
        divresp_rdy = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (check_idle_next) begin
                check("rdy_after_resp", {62'd0, divreq_rdy, divresp_val}, 64'd2);
                check_idle_next = 1'b0;
            end
            if (divresp_val) begin
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_resp actual=0x%0h (cycle %0d)", divresp_msg_result, cyc);
                        divresp_rdy = 1'b1;
                        continue;
                    end
                    cur        = exp_q.pop_front();
                    in_resp    = 1'b1;
                    stall_left = cur.stall;
                    check("latency", 64'(cyc - cur.t_req), 64'(cur.lat));
                end
                check("result", divresp_msg_result, cur.res);
                check("req_rdy_in_done", {63'd0, divreq_rdy}, 64'd0);
                if (stall_left > 0) begin
                    stall_left--;
                    divresp_rdy = 1'b0;
                end else if (cur.stall > 0) begin
                    divresp_rdy = 1'b1;
                end else begin
                    divresp_rdy = ($urandom_range(0, 3) != 0);
                end
                if (divresp_rdy) begin
                    in_resp         = 1'b0;
                    check_idle_next = 1'b1;
                end
            end else begin
                if (in_resp) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_val_dropped before handshake (cycle %0d)", cyc);
                    in_resp = 1'b0;
                end
                divresp_rdy = 1'($urandom);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic        fn;
        logic [31:0] a;
        logic [31:0] b;

        reset         = 1'b1;
        divreq_val    = 1'b0;
        divreq_msg_fn = 1'b0;
        divreq_msg_a  = '0;
        divreq_msg_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_req_rdy", {63'd0, divreq_rdy}, 64'd1);
        check("reset_resp_val", {63'd0, divresp_val}, 64'd0);
        check("reset_result", divresp_msg_result, 64'd0);

        // Directed vectors; the first response is held for 10 cycles and the
        // second request waits on it to exercise back-to-back acceptance.
        do_op(1'b0, 32'h0000_0014, 32'hFFFF_FFFD, 10);
        do_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0010, 0);
        do_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0000, 0);
        do_op(1'b1, 32'h8765_4321, 32'h0000_0000, 0);
        do_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(1'b0, 32'h8000_0000, 32'h0000_0000, 0);
        do_op(1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0);
        do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0);

        for (int i = 0; i < 40; i++) begin
            fn = 1'($urandom);
            a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'h8000_0000 | $urandom;
                default: b = $urandom;
            endcase
            do_op(fn, a, b, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        drain();

        // Abort an operation with reset during its 10th CALC cycle.
        issue(1'b0, 32'h1234_5678, 32'h0000_0007, 1'b0, 0, ok);
        if (ok) begin
            repeat (9) @(posedge clk);
            #1;
            check("busy_before_abort", {63'd0, divreq_rdy}, 64'd0);
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            check("abort_req_rdy", {63'd0, divreq_rdy}, 64'd1);
            check("abort_resp_val", {63'd0, divresp_val}, 64'd0);
            check("abort_result", divresp_msg_result, 64'd0);
            repeat (40) @(posedge clk);
            #1;
        end

        do_op(1'b0, 32'hFFFF_FF9C, 32'h0000_0007, 0);
        do_op(1'b1, 32'h0000_0064, 32'h0000_0007, 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
